// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver front end feeding the RX FIFO
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 fifo_full,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;

    state_t                 state, next_state;
    logic                   rx_meta, rx_s;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_err_q;
    logic                   tick;

    assign tick = (cnt == LAST);
    assign busy = (state != IDLE);

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode; START ends at the half-bit so later ticks land mid-bit
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_s) next_state = START;
            START:   if (cnt == HALF) next_state = rx_s ? IDLE : DATA;
            DATA:    if (tick && bit_cnt == LAST_BIT)
                         next_state = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (tick) next_state = STOP;
            STOP:    if (tick) next_state = rx_s ? IDLE : WAIT_HI;
            WAIT_HI: if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bit-period counter: restarts on every state change and every bit boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state != next_state || tick || state == IDLE || state == WAIT_HI) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shift register, parity tracking and registered single-cycle result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            par_err_q   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt   <= '0;
                    par_err_q <= 1'b0;
                end
                DATA: begin
                    if (tick) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick) par_err_q <= rx_s ^ (^shreg) ^ ODD;
                end
                STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            rx_valid    <= 1'b1;
                            rx_data     <= shreg;
                            parity_err  <= par_err_q;
                            overrun_err <= fifo_full;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core (8N1 and 8E1 instances)
module tb_uart_rx_core;
    localparam int CPB = 16;

    typedef struct {
        logic       fe;
        logic [7:0] d;
        logic       pe;
        logic       oe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic       fifo_full = 1'b0;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, frame_err0, parity_err0, overrun_err0, busy0;
    logic       rx_valid1, frame_err1, parity_err1, overrun_err1, busy1;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .fifo_full(fifo_full),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .frame_err(frame_err0),
        .parity_err(parity_err0), .overrun_err(overrun_err0), .busy(busy0)
    );

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .fifo_full(fifo_full),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .frame_err(frame_err1),
        .parity_err(parity_err1), .overrun_err(overrun_err1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_evt(input string tag, input int have, input exp_t e,
                             input logic v, input logic fe, input logic [7:0] d,
                             input logic pe, input logic oe);
        if (have == 0) begin
            chk({tag, "_unexpected_pulse"}, {28'd0, v, fe, pe, oe}, 32'd0);
        end else begin
            chk({tag, "_frame_err"}, {31'd0, fe}, {31'd0, e.fe});
            chk({tag, "_rx_valid"}, {31'd0, v}, {31'd0, ~e.fe});
            if (!e.fe) begin
                chk({tag, "_rx_data"}, {24'd0, d}, {24'd0, e.d});
                chk({tag, "_parity_err"}, {31'd0, pe}, {31'd0, e.pe});
                chk({tag, "_overrun_err"}, {31'd0, oe}, {31'd0, e.oe});
            end else begin
                chk({tag, "_err_without_valid"}, {30'd0, pe, oe}, 32'd0);
            end
        end
    endtask

    // Monitor for the 8N1 instance
    always @(negedge clk) begin
        exp_t e;
        int have;
        if (rx_valid0 || frame_err0 || parity_err0 || overrun_err0) begin
            have = q0.size();
            if (have != 0) e = q0.pop_front();
            check_evt("u0", have, e, rx_valid0, frame_err0, rx_data0, parity_err0, overrun_err0);
        end
    end

    // Monitor for the 8E1 instance
    always @(negedge clk) begin
        exp_t e;
        int have;
        if (rx_valid1 || frame_err1 || parity_err1 || overrun_err1) begin
            have = q1.size();
            if (have != 0) e = q1.pop_front();
            check_evt("u1", have, e, rx_valid1, frame_err1, rx_data1, parity_err1, overrun_err1);
        end
    end

    task automatic send_bit(input int which, input logic b);
        if (which == 0) rx0 = b;
        else            rx1 = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        send_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(which, d[i]);
        if (has_par) send_bit(which, par);
        send_bit(which, stop);
        if (which == 0) rx0 = 1'b1;
        else            rx1 = 1'b1;
    endtask

    task automatic expect_byte(input int which, input logic [7:0] d, input logic pe, input logic oe);
        exp_t e;
        e.fe = 1'b0; e.d = d; e.pe = pe; e.oe = oe;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    task automatic expect_ferr(input int which);
        exp_t e;
        e.fe = 1'b1; e.d = 8'h00; e.pe = 1'b0; e.oe = 1'b0;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_u0_outs"}, {23'd0, rx_data0, rx_valid0, frame_err0, parity_err0, overrun_err0, busy0}, 32'd0);
        chk({tag, "_u1_outs"}, {23'd0, rx_data1, rx_valid1, frame_err1, parity_err1, overrun_err1, busy1}, 32'd0);
    endtask

    initial begin
        int dropped;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single 8N1 frame
        expect_byte(0, 8'hA5, 1'b0, 1'b0);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);

        // 2: back-to-back frames without idle gap
        expect_byte(0, 8'h00, 1'b0, 1'b0);
        expect_byte(0, 8'hFF, 1'b0, 1'b0);
        expect_byte(0, 8'h3C, 1'b0, 1'b0);
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);

        // 3: 4-cycle glitch is rejected
        rx0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy_high", {31'd0, busy0}, 32'd1);
        rx0 = 1'b1;
        begin
            int k = 0;
            while (busy0 && k < 12) begin
                @(negedge clk);
                k++;
            end
        end
        chk("glitch_busy_drop", {31'd0, busy0}, 32'd0);
        repeat (20) @(negedge clk);

        // 4: stop bit low, line held low, then recovery
        expect_ferr(0);
        send_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(0, i[0] ? 1'b0 : 1'b1);
        send_bit(0, 1'b0);
        rx0 = 1'b0;
        repeat (40) @(negedge clk);
        chk("break_busy_held", {31'd0, busy0}, 32'd1);
        rx0 = 1'b1;
        repeat (8) @(negedge clk);
        chk("break_busy_released", {31'd0, busy0}, 32'd0);
        expect_byte(0, 8'h12, 1'b0, 1'b0);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);

        // 5: even parity, correct then wrong parity bit
        expect_byte(1, 8'h07, 1'b0, 1'b0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        expect_byte(1, 8'h07, 1'b1, 1'b0);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);

        // 6: overrun, then reset mid-frame
        fifo_full = 1'b1;
        expect_byte(0, 8'h81, 1'b0, 1'b1);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        fifo_full = 1'b0;
        repeat (4) @(negedge clk);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        rst_n = 1'b0;
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midframe_reset");
        rst_n = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("post_reset_idle", {31'd0, busy0}, 32'd0);

        dropped = q0.size() + q1.size();
        chk("scoreboard_drained", dropped, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
